// File: rtl/instr_control.sv
// Registered MIPS instruction decoder: op/fuc/RT fields in, one-hot identity flags
// plus multiply/divide group flags out, one cycle later.
module instr_control #(
    parameter int unsigned W_INSTR = 51
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         fuc,
    input  logic [4:0]         RT,
    output logic [W_INSTR-1:0] instr,
    output logic               md_start,
    output logic               md_mt,
    output logic               md_mf,
    output logic               undef
);

    logic [W_INSTR-1:0] instr_d, instr_q;
    logic               md_start_d, md_start_q;
    logic               md_mt_d, md_mt_q;
    logic               md_mf_d, md_mf_q;
    logic               undef_d, undef_q;

    // Field decode to a single flag; unmatched encodings leave every flag clear.
    always_comb begin
        instr_d = '0;
        case (op)
            6'b000000: begin
                case (fuc)
                    6'b100000: instr_d[0]  = 1'b1;
                    6'b100001: instr_d[1]  = 1'b1;
                    6'b100010: instr_d[2]  = 1'b1;
                    6'b100011: instr_d[3]  = 1'b1;
                    6'b100100: instr_d[4]  = 1'b1;
                    6'b100101: instr_d[5]  = 1'b1;
                    6'b100110: instr_d[6]  = 1'b1;
                    6'b100111: instr_d[7]  = 1'b1;
                    6'b101010: instr_d[8]  = 1'b1;
                    6'b101011: instr_d[9]  = 1'b1;
                    6'b000000: instr_d[10] = 1'b1;
                    6'b000010: instr_d[11] = 1'b1;
                    6'b000011: instr_d[12] = 1'b1;
                    6'b000100: instr_d[13] = 1'b1;
                    6'b000110: instr_d[14] = 1'b1;
                    6'b000111: instr_d[15] = 1'b1;
                    6'b001000: instr_d[16] = 1'b1;
                    6'b001001: instr_d[17] = 1'b1;
                    6'b010000: instr_d[18] = 1'b1;
                    6'b010001: instr_d[19] = 1'b1;
                    6'b010010: instr_d[20] = 1'b1;
                    6'b010011: instr_d[21] = 1'b1;
                    6'b011000: instr_d[22] = 1'b1;
                    6'b011001: instr_d[23] = 1'b1;
                    6'b011010: instr_d[24] = 1'b1;
                    6'b011011: instr_d[25] = 1'b1;
                    default:   instr_d     = '0;
                endcase
            end
            6'b011100: instr_d[26] = (fuc == 6'b000000);
            6'b000001: begin
                instr_d[27] = (RT == 5'b00000);
                instr_d[28] = (RT == 5'b00001);
            end
            6'b000010: instr_d[29] = 1'b1;
            6'b000011: instr_d[30] = 1'b1;
            6'b000100: instr_d[31] = 1'b1;
            6'b000101: instr_d[32] = 1'b1;
            6'b000110: instr_d[33] = 1'b1;
            6'b000111: instr_d[34] = 1'b1;
            6'b001000: instr_d[35] = 1'b1;
            6'b001001: instr_d[36] = 1'b1;
            6'b001010: instr_d[37] = 1'b1;
            6'b001011: instr_d[38] = 1'b1;
            6'b001100: instr_d[39] = 1'b1;
            6'b001101: instr_d[40] = 1'b1;
            6'b001110: instr_d[41] = 1'b1;
            6'b001111: instr_d[42] = 1'b1;
            6'b100000: instr_d[43] = 1'b1;
            6'b100001: instr_d[44] = 1'b1;
            6'b100011: instr_d[45] = 1'b1;
            6'b100100: instr_d[46] = 1'b1;
            6'b100101: instr_d[47] = 1'b1;
            6'b101000: instr_d[48] = 1'b1;
            6'b101001: instr_d[49] = 1'b1;
            6'b101011: instr_d[50] = 1'b1;
            default:   instr_d     = '0;
        endcase
    end

    // Group flags derive from the same decode so they can never disagree with instr.
    always_comb begin
        md_start_d = instr_d[22] | instr_d[23] | instr_d[24] | instr_d[25] | instr_d[26];
        md_mt_d    = instr_d[19] | instr_d[21];
        md_mf_d    = instr_d[18] | instr_d[20];
        undef_d    = ~(|instr_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q    <= '0;
            md_start_q <= 1'b0;
            md_mt_q    <= 1'b0;
            md_mf_q    <= 1'b0;
            undef_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            md_start_q <= md_start_d;
            md_mt_q    <= md_mt_d;
            md_mf_q    <= md_mf_d;
            undef_q    <= undef_d;
        end
    end

    assign instr    = instr_q;
    assign md_start = md_start_q;
    assign md_mt    = md_mt_q;
    assign md_mf    = md_mf_q;
    assign undef    = undef_q;

endmodule

// File: tb/tb_instr_control.sv
// Scoreboard bench for instr_control: stimulus queues expected decodes, a monitor
// pops one after each capturing edge and compares.
module tb_instr_control;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  fuc;
    logic [4:0]  RT;
    logic [50:0] instr;
    logic        md_start, md_mt, md_mf, undef;

    instr_control dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .fuc      (fuc),
        .RT       (RT),
        .instr    (instr),
        .md_start (md_start),
        .md_mt    (md_mt),
        .md_mf    (md_mf),
        .undef    (undef)
    );

    typedef struct {
        logic [50:0] instr;
        logic        md_start;
        logic        md_mt;
        logic        md_mf;
        logic        undef;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [5:0] r_fuc [26] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                               6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                               6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                               6'b000111, 6'b001000, 6'b001001, 6'b010000, 6'b010001,
                               6'b010010, 6'b010011, 6'b011000, 6'b011001, 6'b011010,
                               6'b011011};
    logic [5:0] i_op [22]  = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b000110,
                               6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                               6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b100000,
                               6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101000,
                               6'b101001, 6'b101011};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a flag index; -1 means undefined encoding.
    function automatic exp_t mk_exp(input int idx, input string nm);
        exp_t e;
        e.instr    = '0;
        e.md_start = 1'b0;
        e.md_mt    = 1'b0;
        e.md_mf    = 1'b0;
        e.undef    = (idx < 0);
        e.name     = nm;
        if (idx >= 0) e.instr[idx] = 1'b1;
        if (idx >= 22 && idx <= 26) e.md_start = 1'b1;
        if (idx == 19 || idx == 21) e.md_mt = 1'b1;
        if (idx == 18 || idx == 20) e.md_mf = 1'b1;
        return e;
    endfunction

    function automatic exp_t mk_rst(input string nm);
        exp_t e;
        e = mk_exp(0, nm);
        e.instr = '0;
        return e;
    endfunction

    task automatic drive(input logic rst_v, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] r, input int idx, input string nm);
        @(negedge clk);
        reset = rst_v;
        op    = o;
        fuc   = f;
        RT    = r;
        if (rst_v) exp_q.push_back(mk_exp(idx, nm));
        else       exp_q.push_back(mk_rst(nm));
    endtask

    task automatic check_now(input string nm, input exp_t e);
        n_tests++;
        if (instr !== e.instr || md_start !== e.md_start || md_mt !== e.md_mt ||
            md_mf !== e.md_mf || undef !== e.undef) begin
            n_fail++;
            $display("FAIL %s: got instr=%h st/mt/mf/ud=%b%b%b%b want instr=%h st/mt/mf/ud=%b%b%b%b",
                     nm, instr, md_start, md_mt, md_mf, undef,
                     e.instr, e.md_start, e.md_mt, e.md_mf, e.undef);
        end
    endtask

    // Monitor: one pop per capturing edge, plus the one-hot/undef invariant out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset === 1'b1) begin
                n_tests++;
                if ($countones(instr) + int'(undef) != 1) begin
                    n_fail++;
                    $display("FAIL onehot: got popcount=%0d undef=%b want sum 1",
                             $countones(instr), undef);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now(e.name, e);
            end
        end
    end

    initial begin
        int k;
        reset = 1'b0;
        op    = 6'b000000;
        fuc   = 6'b011000;
        RT    = 5'b00000;
        #1;
        check_now("reset_init", mk_rst("reset_init"));

        // Held in reset with mult on the inputs, then release.
        for (int i = 0; i < 3; i++) drive(1'b0, 6'b000000, 6'b011000, 5'd0, 0, "reset_hold");
        drive(1'b1, 6'b000000, 6'b011000, 5'd0, 22, "reset_release_mult");

        // R-type sweep
        for (int i = 0; i < 26; i++) drive(1'b1, 6'b000000, r_fuc[i], 5'd0, i, $sformatf("rtype_%0d", i));
        drive(1'b1, 6'b000000, 6'b000001, 5'd0, -1, "rtype_undef_000001");
        drive(1'b1, 6'b000000, 6'b101100, 5'd0, -1, "rtype_undef_101100");
        drive(1'b1, 6'b000000, 6'b010000, 5'd3, 18, "mfhi_md_mf");
        drive(1'b1, 6'b000000, 6'b000000, 5'd0, 10, "nop_sll");

        // REGIMM and madd
        drive(1'b1, 6'b000001, 6'b111111, 5'b00000, 27, "bltz");
        drive(1'b1, 6'b000001, 6'b000000, 5'b00001, 28, "bgez");
        drive(1'b1, 6'b000001, 6'b000000, 5'b10001, -1, "regimm_undef");
        drive(1'b1, 6'b011100, 6'b000000, 5'd7, 26, "madd");
        drive(1'b1, 6'b011100, 6'b000010, 5'd0, -1, "op1c_undef");

        // I/J sweep with random don't-care fields
        for (int i = 0; i < 22; i++)
            drive(1'b1, i_op[i], 6'($urandom_range(63)), 5'($urandom_range(31)), 29 + i,
                  $sformatf("ij_%0d", 29 + i));
        drive(1'b1, 6'b111111, 6'b000000, 5'd0, -1, "op_undef_111111");

        // Back-to-back random encodings drawn from the known tables
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(3));
            if (k == 0) begin
                k = int'($urandom_range(25));
                drive(1'b1, 6'b000000, r_fuc[k], 5'($urandom_range(31)), k, "rand_r");
            end else if (k == 1) begin
                k = int'($urandom_range(21));
                drive(1'b1, i_op[k], 6'($urandom_range(63)), 5'($urandom_range(31)), 29 + k, "rand_ij");
            end else if (k == 2) begin
                k = int'($urandom_range(1));
                drive(1'b1, 6'b000001, 6'($urandom_range(63)), 5'(k), 27 + k, "rand_regimm");
            end else begin
                drive(1'b1, 6'b011100, 6'b000001, 5'd0, -1, "rand_undef");
            end
        end

        // Asynchronous reset while lw is on the outputs
        drive(1'b1, 6'b100011, 6'b000000, 5'd0, 45, "lw_before_reset");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_now("async_reset_clear", mk_rst("async_reset_clear"));
        drive(1'b0, 6'b000000, 6'b100001, 5'd0, 0, "async_reset_hold");
        drive(1'b1, 6'b000000, 6'b100001, 5'd0, 1, "after_reset_addu");

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
